i2c_byte_sequencer: RTL
=======================

# i2c_byte_sequencer

Byte-level command sequencer sitting between the I2C master register interface and the bit controller. It expands one byte command (optional START, 8-bit WRITE or READ, ACK phase, optional STOP) into a series of bit-controller commands. It shifts transmit data out MSB first, shifts received data in, and reports the acknowledge and arbitration-loss outcomes back to the requester.

## Interface
- Parameters: none. Bit-command encodings come from the shared package.
- clk  in  1  system clock
- nReset  in  1  asynchronous reset, active-low
- rst  in  1  synchronous reset, active-high
- start  in  1  request START before the byte
- stop  in  1  request STOP after the byte
- read  in  1  receive one byte
- write  in  1  transmit one byte
- ack_in  in  1  ACK bit to drive after a read (0 = ACK, 1 = NACK)
- din  in  8  transmit byte
- cmd_ack  out  1  one-cycle pulse: byte command complete
- ack_out  out  1  ACK bit sampled from slave after write/read
- dout  out  8  received byte (shift register contents)
- i2c_al  out  1  one-cycle pulse: arbitration lost
- core_cmd  out  4  bit command: NOP 0000, START 0001, STOP 0010, WRITE 0100, READ 1000
- core_txd  out  1  bit to transmit with WRITE
- core_ack  in  1  bit controller command done (one-cycle pulse)
- core_al  in  1  bit controller arbitration lost
- core_rxd  in  1  bit received by bit controller

## Operation
- States: IDLE, START, WRITE, READ, ACK, STOP. All outputs are registered.
- IDLE accepts when `go = (read|write|stop) & ~cmd_ack`. `start` alone is never accepted.
- On accept:
  - Load `sr <= din` and `dcnt <= 7`.
  - Priority for the next state: start→START (cmd START), else read→READ (cmd READ), else write→WRITE (cmd WRITE, `core_txd = din[7]`), else STOP (cmd STOP).
- All non-IDLE states act only on `core_ack`; `core_cmd` is held until then.
- START on `core_ack`: go to READ if `read`, else WRITE with `core_txd = sr[7]`.
- WRITE/READ on `core_ack`:
  - Shift: `sr <= {sr[6:0], core_rxd}`.
  - If `dcnt != 0`: decrement `dcnt`, reissue the same cmd, `core_txd = sr[6]`.
  - If `dcnt == 0`: go to ACK. After WRITE issue READ; after READ issue WRITE with `core_txd = ack_in`.
- ACK on `core_ack`:
  - Set `ack_out <= core_rxd` and `core_txd <= 1`.
  - If `stop`: go to STOP, cmd STOP.
  - Otherwise: go to IDLE, cmd NOP, pulse `cmd_ack`.
- STOP on `core_ack`: go to IDLE, cmd NOP, pulse `cmd_ack`.
- `dout = sr` at all times. Only the byte present at the `cmd_ack` pulse is valid.
- `core_al` in any state:
  - Next cycle: state IDLE, `core_cmd` NOP, `cmd_ack` 0, `i2c_al` 1 for exactly one cycle.
  - `core_al` takes priority over `core_ack` in the same cycle.
- `rst` has the same effect as `nReset`, but synchronous. `rst` mid-byte aborts with no `cmd_ack` and no `i2c_al`.
- Reset values: state IDLE, `core_cmd` 0000, `core_txd` 0, `cmd_ack` 0, `ack_out` 0, `dout`/`sr` 00, `dcnt` 0, `i2c_al` 0.

## Timing
- Accept to first non-NOP `core_cmd`: 1 cycle.
- `core_ack` to next `core_cmd`/`core_txd`: 1 cycle. Every `core_ack` also produces its `cmd_ack` one cycle later where one is due.
- The requester must deassert start/stop/read/write in the cycle `cmd_ack` is high. The `~cmd_ack` term in `go` blocks re-acceptance in that cycle.
- Bit transactions per command: write/read = 9; +1 with START; +1 with STOP; stop-only = 1.
- `dcnt` is 3 bits and never wraps. Decrement happens only while `dcnt != 0`.

## Structure
- Shared package `i2c_pkg` holds:
  - bit-command constants CMD_NOP/START/STOP/WRITE/READ (4-bit one-hot);
  - the byte-state enum.
- The bit controller imports the same constants.
- Sub-module `i2c_shift_cnt` (8-bit shift register + 3-bit down counter, load/shift/done) is natural. Everything else stays in this block.

## Test plan
- Bench: a bit-controller model returning `core_ack` 4 cycles after each non-NOP cmd and driving a scripted `core_rxd`.
- start+write, din=A5, rxd ack=0 → cmd sequence START, WRITE×8 with txd 1,0,1,0,0,1,0,1, then READ. `ack_out` = 0. One `cmd_ack` pulse.
- read+stop+ack_in=1, rxd bits 3C → READ×8, WRITE with txd=1, STOP. `dout` = 3C at `cmd_ack`.
- stop only → single STOP cmd, `cmd_ack` one cycle after its `core_ack`. start only → no accept, `core_cmd` stays NOP.
- write, `core_al` asserted during bit 3 → next cycle IDLE, NOP, `i2c_al` pulse of 1 cycle, no `cmd_ack`. A new write is then accepted normally.
- `rst` asserted mid-read, and separately `core_al` and `core_ack` in the same cycle → all outputs at reset values (`rst` case); `i2c_al` wins (simultaneous case). Requester holding write through `cmd_ack` for 1 cycle → no double accept.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bit-controller command encodings and byte-level sequencer states.
package i2c_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWrite,
        StRead,
        StAck,
        StStop
    } byte_state_e;

endpackage

// File: rtl/i2c_shift_cnt.sv
// Byte shift register with 3-bit bit counter; loads the transmit byte, shifts received bits in.
module i2c_shift_cnt (
    input  logic       clk,
    input  logic       nReset,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    input  logic       rxd,
    output logic [7:0] sr,
    output logic [2:0] dcnt,
    output logic       done
);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sr   <= 8'h00;
            dcnt <= 3'd0;
        end else if (rst) begin
            sr   <= 8'h00;
            dcnt <= 3'd0;
        end else if (load) begin
            sr   <= din;
            dcnt <= 3'd7;
        end else if (shift) begin
            sr <= {sr[6:0], rxd};
            // Counter saturates at zero; the last shift of a byte happens with dcnt already 0
            if (dcnt != 3'd0) begin
                dcnt <= dcnt - 3'd1;
            end
        end
    end

    assign done = (dcnt == 3'd0);

endmodule

// File: rtl/i2c_byte_sequencer.sv
// Expands one byte command (START, WRITE/READ, ACK, STOP) into bit-controller commands.
module i2c_byte_sequencer
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       nReset,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       read,
    input  logic       write,
    input  logic       ack_in,
    input  logic [7:0] din,
    output logic       cmd_ack,
    output logic       ack_out,
    output logic [7:0] dout,
    output logic       i2c_al,
    output logic [3:0] core_cmd,
    output logic       core_txd,
    input  logic       core_ack,
    input  logic       core_al,
    input  logic       core_rxd
);

    byte_state_e state;
    logic        go;
    logic        load;
    logic        shift;
    logic [7:0]  sr;
    logic [2:0]  dcnt;
    logic        done;

    // cmd_ack term keeps a still-asserted request from being re-accepted in the completion cycle
    assign go    = (read | write | stop) & ~cmd_ack;
    assign load  = (state == StIdle) & go & ~core_al;
    assign shift = ((state == StWrite) | (state == StRead)) & core_ack & ~core_al;
    assign dout  = sr;

    i2c_shift_cnt u_shift_cnt (
        .clk    (clk),
        .nReset (nReset),
        .rst    (rst),
        .load   (load),
        .shift  (shift),
        .din    (din),
        .rxd    (core_rxd),
        .sr     (sr),
        .dcnt   (dcnt),
        .done   (done)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= StIdle;
            core_cmd <= CMD_NOP;
            core_txd <= 1'b0;
            cmd_ack  <= 1'b0;
            ack_out  <= 1'b0;
            i2c_al   <= 1'b0;
        end else if (rst) begin
            state    <= StIdle;
            core_cmd <= CMD_NOP;
            core_txd <= 1'b0;
            cmd_ack  <= 1'b0;
            ack_out  <= 1'b0;
            i2c_al   <= 1'b0;
        end else begin
            cmd_ack <= 1'b0;
            i2c_al  <= core_al;
            if (core_al) begin
                state    <= StIdle;
                core_cmd <= CMD_NOP;
            end else begin
                case (state)
                    StIdle: begin
                        if (go) begin
                            if (start) begin
                                state    <= StStart;
                                core_cmd <= CMD_START;
                            end else if (read) begin
                                state    <= StRead;
                                core_cmd <= CMD_READ;
                            end else if (write) begin
                                state    <= StWrite;
                                core_cmd <= CMD_WRITE;
                                core_txd <= din[7];
                            end else begin
                                state    <= StStop;
                                core_cmd <= CMD_STOP;
                            end
                        end
                    end
                    StStart: begin
                        if (core_ack) begin
                            if (read) begin
                                state    <= StRead;
                                core_cmd <= CMD_READ;
                            end else begin
                                state    <= StWrite;
                                core_cmd <= CMD_WRITE;
                                core_txd <= sr[7];
                            end
                        end
                    end
                    StWrite, StRead: begin
                        if (core_ack) begin
                            if (!done) begin
                                core_txd <= sr[6];
                            end else begin
                                state <= StAck;
                                if (state == StWrite) begin
                                    core_cmd <= CMD_READ;
                                end else begin
                                    core_cmd <= CMD_WRITE;
                                    core_txd <= ack_in;
                                end
                            end
                        end
                    end
                    StAck: begin
                        if (core_ack) begin
                            ack_out  <= core_rxd;
                            core_txd <= 1'b1;
                            if (stop) begin
                                state    <= StStop;
                                core_cmd <= CMD_STOP;
                            end else begin
                                state    <= StIdle;
                                core_cmd <= CMD_NOP;
                                cmd_ack  <= 1'b1;
                            end
                        end
                    end
                    StStop: begin
                        if (core_ack) begin
                            state    <= StIdle;
                            core_cmd <= CMD_NOP;
                            cmd_ack  <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= StIdle;
                        core_cmd <= CMD_NOP;
                    end
                endcase
            end
        end
    end

endmodule
